// File: rtl/line_memory_responder_if.sv
// Line-granular memory request/response channel between the memory
// controller (master) and the backing-store responder (slave).
interface line_memory_responder_if #(
  parameter int ARCH_LEN  = 32,
  parameter int LINE_BITS = 128
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ARCH_LEN-1:0]  req_addr;
  logic [LINE_BITS-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [LINE_BITS-1:0] resp_rdata;
  logic                 resp_err;
  logic [31:0]          resp_count;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_count
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_count
  );
endinterface

// File: rtl/line_memory_responder.sv
// Responder end of the line memory channel: accepts one line read or write
// at a time, holds it for LATENCY cycles, commits/fetches the line, then
// holds the response until the controller consumes it.
module line_memory_responder #(
  parameter int ARCH_LEN  = 32,
  parameter int LINE_BITS = 128,
  parameter int MEM_LINES = 4096,
  parameter int LATENCY   = 5
) (
  input  logic clk,
  input  logic rst,
  line_memory_responder_if.slave bus
);
  localparam int OFF_BITS  = $clog2(LINE_BITS / 8);
  localparam int IDX_BITS  = $clog2(MEM_LINES);
  localparam int CNT_BITS  = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q;
  logic                  wr_q;
  logic                  err_q;
  logic [IDX_BITS-1:0]   idx_q;
  logic [LINE_BITS-1:0]  wdata_q;
  logic [LINE_BITS-1:0]  rdata_q;
  logic                  resp_err_q;
  logic [31:0]           count_q;

  logic                  accept;
  logic                  commit;
  logic                  consume;
  logic                  addr_err;
  logic [IDX_BITS-1:0]   req_idx;

  logic [LINE_BITS-1:0]  mem [MEM_LINES];

  // Address decode: a line must be aligned and lie inside the array.
  assign req_idx  = bus.req_addr[OFF_BITS +: IDX_BITS];
  assign addr_err = (bus.req_addr[OFF_BITS-1:0] != '0) ||
                    ((bus.req_addr >> (OFF_BITS + IDX_BITS)) != '0);

  // Ready is withheld during reset so nothing is accepted on that edge.
  assign bus.req_ready  = (state_q == IDLE) && !rst;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_count = count_q;

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        accept  = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (cnt_q == CNT_BITS'(1)) begin
        commit  = 1'b1;
        state_d = RESP;
      end
      RESP: if (bus.resp_ready) begin
        consume = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latency counter, captured request and response registers.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= bus.req_write;
        err_q   <= addr_err;
        idx_q   <= req_idx;
        wdata_q <= bus.req_wdata;
        cnt_q   <= CNT_BITS'(LATENCY);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_BITS'(1);
      end
      if (commit) begin
        resp_err_q <= err_q;
        rdata_q    <= (!wr_q && !err_q) ? mem[idx_q] : '0;
      end else if (consume) begin
        resp_err_q <= 1'b0;
        rdata_q    <= '0;
        count_q    <= count_q + 32'd1;
      end
    end
  end

  // Line array write port; a write still in flight when reset hits is dropped.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; clearing thousands of lines is not wanted and contents survive rst.
    if (!rst && commit && wr_q && !err_q)
      mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_line_memory_responder.sv
// Self-checking bench: a LATENCY=5 responder for the functional scenarios
// and a LATENCY=1 responder for back-to-back throughput.
module tb_line_memory_responder;
  localparam int LAT_A = 5;
  localparam int LAT_B = 1;

  typedef struct {
    logic [127:0] rdata;
    logic         err;
  } exp_t;

  logic clk;
  logic rst;

  line_memory_responder_if #(.ARCH_LEN(32), .LINE_BITS(128)) bus_a ();
  line_memory_responder_if #(.ARCH_LEN(32), .LINE_BITS(128)) bus_b ();

  line_memory_responder #(.LATENCY(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  line_memory_responder #(.LATENCY(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.resp_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t         q_a[$];
  int           acc_a[$];
  logic [127:0] model_a [int];
  int unsigned  exp_cnt_a = 0;

  exp_t         q_b[$];
  int           acc_b[$];
  logic [127:0] model_b [4];

  localparam logic [127:0] DATA_W   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DATA_OLD = 128'hC0FFEE00C0FFEE00C0FFEE00C0FFEE00;
  localparam logic [127:0] DATA_NEW = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one request on bus_a and push its expected response.
  task automatic issue_a(input logic wr, input logic [31:0] addr, input logic [127:0] data);
    int   w;
    exp_t e;
    int   idx;
    w = 0;
    while (!bus_a.req_ready && w < 50) begin
      step();
      w++;
    end
    n_checks++;
    if (!bus_a.req_ready) begin
      n_fail++;
      $display("FAIL issue_ready: req_ready=%0b required 1", bus_a.req_ready);
    end
    bus_a.req_valid = 1'b1;
    bus_a.req_write = wr;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = data;
    step();
    bus_a.req_valid = 1'b0;
    acc_a.push_back(cyc);
    idx   = int'(addr[15:4]);
    e.err = (addr[3:0] != 4'h0) || (addr >= 32'h0001_0000);
    if (!wr && !e.err)
      e.rdata = model_a.exists(idx) ? model_a[idx] : 128'h0;
    else
      e.rdata = 128'h0;
    if (wr && !e.err)
      model_a[idx] = data;
    q_a.push_back(e);
  endtask

  // Wait for the response (resp_ready already high), score it, consume it.
  task automatic collect_a(input string name);
    int   w;
    int   acc;
    exp_t e;
    w = 0;
    while (!bus_a.resp_valid && w < 300) begin
      step();
      w++;
    end
    n_checks++;
    if (!bus_a.resp_valid || q_a.size() == 0) begin
      n_fail++;
      $display("FAIL %s timeout: resp_valid=%0b queued=%0d", name, bus_a.resp_valid, q_a.size());
      if (q_a.size() > 0) begin
        void'(q_a.pop_front());
        void'(acc_a.pop_front());
      end
      return;
    end
    e   = q_a.pop_front();
    acc = acc_a.pop_front();
    n_checks++;
    if (cyc - acc !== LAT_A) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, cyc - acc, LAT_A);
    end
    n_checks++;
    if (bus_a.resp_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL %s rdata: got %h required %h", name, bus_a.resp_rdata, e.rdata);
    end
    n_checks++;
    if (bus_a.resp_err !== e.err) begin
      n_fail++;
      $display("FAIL %s err: got %0b required %0b", name, bus_a.resp_err, e.err);
    end
    n_checks++;
    if (bus_a.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_in_resp: got %0b required 0", name, bus_a.req_ready);
    end
    step();
    exp_cnt_a++;
    n_checks++;
    if (bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_consume: resp_valid=%0b req_ready=%0b required 0/1",
               name, bus_a.resp_valid, bus_a.req_ready);
    end
    n_checks++;
    if (bus_a.resp_count !== exp_cnt_a) begin
      n_fail++;
      $display("FAIL %s count: got %0d required %0d", name, bus_a.resp_count, exp_cnt_a);
    end
  endtask

  task automatic test_preload();
    issue_a(1'b1, 32'h0000_0000, 128'h0);
    collect_a("preload_line0");
    issue_a(1'b1, 32'h0000_0050, 128'h0);
    collect_a("preload_0x50");
    issue_a(1'b1, 32'h0000_0080, DATA_OLD);
    collect_a("preload_0x80");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (bus_a.req_ready !== 1'b0 || bus_a.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: req_ready=%0b resp_valid=%0b required 0/0",
               bus_a.req_ready, bus_a.resp_valid);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus_a.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: got %0b required 1", bus_a.req_ready);
    end
    n_checks++;
    if (bus_a.resp_count !== 32'd0 || bus_a.resp_rdata !== 128'h0 || bus_a.resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: count=%0d rdata=%h err=%0b required 0",
               bus_a.resp_count, bus_a.resp_rdata, bus_a.resp_err);
    end
    exp_cnt_a = 0;
  endtask

  task automatic test_write();
    issue_a(1'b1, 32'h0000_0040, DATA_W);
    collect_a("write_0x40");
  endtask

  task automatic test_read();
    issue_a(1'b0, 32'h0000_0040, 128'h0);
    collect_a("read_0x40");
    issue_a(1'b0, 32'h0000_0050, 128'h0);
    collect_a("read_0x50");
  endtask

  task automatic test_backpressure();
    int   w;
    int   acc;
    int   bad;
    exp_t e;
    bus_a.resp_ready = 1'b0;
    issue_a(1'b0, 32'h0000_0040, 128'h0);
    w = 0;
    while (!bus_a.resp_valid && w < 300) begin
      step();
      w++;
    end
    e   = q_a.pop_front();
    acc = acc_a.pop_front();
    n_checks++;
    if (!bus_a.resp_valid || cyc - acc !== LAT_A) begin
      n_fail++;
      $display("FAIL bp_latency: resp_valid=%0b got %0d required %0d", bus_a.resp_valid, cyc - acc, LAT_A);
    end
    // A write held on the request side must be ignored while a response is pending.
    bus_a.req_valid = 1'b1;
    bus_a.req_write = 1'b1;
    bus_a.req_addr  = 32'h0000_0040;
    bus_a.req_wdata = DATA_NEW;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus_a.resp_valid !== 1'b1 || bus_a.resp_rdata !== e.rdata ||
          bus_a.resp_err !== e.err || bus_a.req_ready !== 1'b0)
        bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles required 0 (rdata=%h exp=%h)", bad, bus_a.resp_rdata, e.rdata);
    end
    bus_a.resp_ready = 1'b1;
    step();
    bus_a.req_valid = 1'b0;
    exp_cnt_a++;
    n_checks++;
    if (bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: resp_valid=%0b req_ready=%0b required 0/1", bus_a.resp_valid, bus_a.req_ready);
    end
    n_checks++;
    if (bus_a.resp_count !== exp_cnt_a) begin
      n_fail++;
      $display("FAIL bp_count: got %0d required %0d", bus_a.resp_count, exp_cnt_a);
    end
    issue_a(1'b0, 32'h0000_0040, 128'h0);
    collect_a("bp_reread");
  endtask

  task automatic test_errors();
    issue_a(1'b0, 32'h0000_0044, 128'h0);
    collect_a("err_misaligned");
    issue_a(1'b0, 32'h0001_0000, 128'h0);
    collect_a("err_range_read");
    issue_a(1'b1, 32'h0001_0000, {4{32'hFFFF_FFFF}});
    collect_a("err_range_write");
    issue_a(1'b0, 32'h0000_0000, 128'h0);
    collect_a("err_line0_intact");
  endtask

  task automatic test_reset_mid();
    int bad;
    int w;
    w = 0;
    while (!bus_a.req_ready && w < 50) begin
      step();
      w++;
    end
    bus_a.req_valid = 1'b1;
    bus_a.req_write = 1'b1;
    bus_a.req_addr  = 32'h0000_0080;
    bus_a.req_wdata = DATA_NEW;
    step();
    bus_a.req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt_a = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_a.resp_valid !== 1'b0)
        bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midrst_no_resp: resp_valid high %0d cycles required 0", bad);
    end
    n_checks++;
    if (bus_a.resp_count !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d required 0", bus_a.resp_count);
    end
    issue_a(1'b0, 32'h0000_0080, 128'h0);
    collect_a("midrst_old_data");
  endtask

  task automatic set_b(input int i);
    if (i < 4) begin
      bus_b.req_write = 1'b1;
      bus_b.req_addr  = 32'(i * 16);
      bus_b.req_wdata = {4{32'hA500_0000 + 32'(i)}};
    end else begin
      bus_b.req_write = 1'b0;
      bus_b.req_addr  = 32'((i - 4) * 16);
      bus_b.req_wdata = 128'h0;
    end
  endtask

  task automatic test_back_to_back();
    int   idx;
    int   last_acc;
    int   acc;
    bit   acc_now;
    exp_t e;
    idx      = 0;
    last_acc = -1;
    set_b(0);
    bus_b.req_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (idx >= 8 && q_b.size() == 0) break;
      n_checks++;
      if (bus_b.req_ready === 1'b1 && bus_b.resp_valid === 1'b1) begin
        n_fail++;
        $display("FAIL b2b_exclusive: req_ready and resp_valid both high at cycle %0d", cyc);
      end
      if (bus_b.resp_valid === 1'b1) begin
        n_checks++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected: response with empty scoreboard at cycle %0d", cyc);
        end else begin
          e   = q_b.pop_front();
          acc = acc_b.pop_front();
          if (cyc - acc !== LAT_B || bus_b.resp_rdata !== e.rdata || bus_b.resp_err !== e.err) begin
            n_fail++;
            $display("FAIL b2b_resp: lat=%0d rdata=%h err=%0b required lat=%0d rdata=%h err=%0b",
                     cyc - acc, bus_b.resp_rdata, bus_b.resp_err, LAT_B, e.rdata, e.err);
          end
        end
      end
      acc_now = (bus_b.req_ready === 1'b1) && (idx < 8);
      if (acc_now) begin
        e.err   = 1'b0;
        e.rdata = (idx < 4) ? 128'h0 : model_b[idx - 4];
        if (idx < 4)
          model_b[idx] = bus_b.req_wdata;
        q_b.push_back(e);
        acc_b.push_back(cyc + 1);
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc + 1 - last_acc !== LAT_B + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d required %0d", cyc + 1 - last_acc, LAT_B + 2);
          end
        end
        last_acc = cyc + 1;
      end
      step();
      if (acc_now) begin
        idx++;
        if (idx < 8)
          set_b(idx);
        else
          bus_b.req_valid = 1'b0;
      end
    end
    bus_b.req_valid = 1'b0;
    n_checks++;
    if (idx != 8 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_complete: accepted %0d required 8, pending %0d required 0", idx, q_b.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_a.req_valid  = 1'b0;
    bus_a.req_write  = 1'b0;
    bus_a.req_addr   = '0;
    bus_a.req_wdata  = '0;
    bus_a.resp_ready = 1'b1;
    bus_b.req_valid  = 1'b0;
    bus_b.req_write  = 1'b0;
    bus_b.req_addr   = '0;
    bus_b.req_wdata  = '0;
    step();
    step();
    rst = 1'b0;
    test_preload();
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/line_memory_responder.md
Name: line_memory_responder

Overview:
- Responder end of the line-granular memory request/response channel driven by the memory controller.
- Accepts one cache-line read or write at a time and holds it for a programmable access latency.
- Commits the write or fetches the read line, then presents a response that is held until the controller consumes it.
- Used as the backing store below the controller, and as a latency-accurate memory model for pipeline stall testing.

Parameters:
- ARCH_LEN, 32, address width in bits.
- LINE_BITS, 128, cache line width in bits (16 bytes per line).
- MEM_LINES, 4096, number of lines in the backing array; power of two.
- LATENCY, 5, cycles from request acceptance to response; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  controller presents a request
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = line write, 0 = line read
- req_addr  in  ARCH_LEN  byte address of the line
- req_wdata  in  LINE_BITS  write line data
- resp_valid  out  1  response available
- resp_ready  in  1  controller consumes the response
- resp_rdata  out  LINE_BITS  read line data; 0 for writes and errors
- resp_err  out  1  address misaligned or out of range
- resp_count  out  32  number of responses consumed since reset

Behaviour:
- Reset (rst high at a posedge):
  - state=IDLE; req_ready=0 during the reset cycle, 1 on the first cycle after rst deasserts.
  - resp_valid=0, resp_rdata=0, resp_err=0, resp_count=0, latency counter=0.
  - Any in-flight request is dropped; a pending write is NOT committed.
  - Array contents are not reset.
- Line index = req_addr[log2(LINE_BITS/8) +: log2(MEM_LINES)].
- Error = req_addr[3:0] != 0, or req_addr >= MEM_LINES*LINE_BITS/8.
- States:
  - IDLE:
    - req_ready=1.
    - On req_valid&req_ready at edge T, capture write, addr, wdata and err; load cnt=LATENCY; go to WAIT.
  - WAIT:
    - req_ready=0; cnt decrements each edge.
    - At the edge where cnt==1, go to RESP. resp_valid is therefore first high after edge T+LATENCY.
    - On that transition edge:
      - Read, no error: resp_rdata = array[index].
      - Write, no error: array[index] = wdata, and resp_rdata = 0.
      - Error: no array access, resp_rdata=0, resp_err=1.
  - RESP:
    - resp_valid=1. resp_rdata and resp_err are stable while resp_ready=0.
    - On a resp_valid&resp_ready edge: resp_count += 1 (wraps at 2^32), go to IDLE, and clear resp_valid, resp_rdata and resp_err.
- Handshake and ordering:
  - req_ready and resp_valid are never high together.
  - No request is accepted in the cycle its predecessor's response is consumed; minimum spacing between acceptances is LATENCY+2 cycles.
  - Request inputs are ignored outside IDLE, including req_valid held high.
  - Read-after-write to the same line returns the written data.
  - A single write-then-read pair is fully ordered because there is only one outstanding request.
- LATENCY=1 is valid: accept at T, resp_valid after T+1.
- rst during RESP drops the response (it is never consumed) and does not increment resp_count.

Test Plan:
- Reset, then write addr 0x0000_0040 data 0x0123..CDEF (128b), resp_ready=1 -> resp_valid exactly 5 cycles after the accept edge, resp_rdata=0, resp_err=0, resp_count=1.
- Read addr 0x40 after that write -> resp_rdata=0x0123..CDEF after 5 cycles, resp_count=2; read 0x50 (never written, array preloaded 0) -> 0.
- Backpressure: read with resp_ready=0 for 7 cycles -> resp_valid and resp_rdata stable, req_ready=0, a second req_valid is ignored; resp_ready=1 -> IDLE, req_ready=1 on the following cycle.
- Errors: read addr 0x44 (misaligned) and 0x0001_0000 (== 64 KiB, out of range) -> resp_err=1, rdata=0; write to 0x0001_0000 leaves line 0 unchanged.
- Reset mid-operation: write 0x80 accepted, rst asserted 2 cycles later -> resp_valid never rises, resp_count=0, subsequent read of 0x80 returns the old contents.
- LATENCY=1 build: back-to-back reads with resp_ready tied high -> acceptances every 3 cycles, each resp_valid 1 cycle after its accept edge.
